// File: rtl/regfile_pkg.sv
// Shared types and defaults for the arbitrated 16x8 register file.
package regfile_pkg;
  localparam int DATA_W = 8;
  localparam int ADDR_W = 4;

  typedef enum logic {
    CLEAR = 1'b0,
    IDLE  = 1'b1
  } state_t;

  localparam logic REQ_P0 = 1'b0;
  localparam logic REQ_P1 = 1'b1;
endpackage

// File: rtl/regfile_core.sv
// Register file storage: one synchronous write port and
// one registered read port, one access per clock.
module regfile_core #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4
) (
  input  logic              clock,
  input  logic              rst_n,
  input  logic              we,
  input  logic              re,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);
  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clock) begin
    if (we) mem[addr] <= wdata;
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n)  rdata <= '0;
    else if (re) rdata <= mem[addr];
  end
endmodule

// File: rtl/regfile_arbiter.sv
// Round-robin two-port arbiter in front of regfile_core.
// Define REGFILE_CLEAR_SWEEP_EN to zero the array after reset.
module regfile_arbiter
  import regfile_pkg::*;
#(
  parameter int DATA_W = regfile_pkg::DATA_W,
  parameter int ADDR_W = regfile_pkg::ADDR_W
) (
  input  logic              clock,
  input  logic              rst_n,
  input  logic              req0,
  input  logic              we0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [DATA_W-1:0] wdata0,
  input  logic              req1,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata1,
  output logic              gnt0,
  output logic              gnt1,
  output logic [DATA_W-1:0] rdata,
  output logic              rvalid,
  output logic              rid,
  output logic              busy
);
`ifdef REGFILE_CLEAR_SWEEP_EN
  localparam state_t RST_STATE = CLEAR;
`else
  localparam state_t RST_STATE = IDLE;
`endif

  state_t            state;
  state_t            state_nxt;
  logic              rr;
  logic [ADDR_W-1:0] sweep_idx;
  logic              pick0;
  logic              pick1;
  logic              c_we;
  logic              c_re;
  logic [ADDR_W-1:0] c_addr;
  logic [DATA_W-1:0] c_wdata;

  always_comb begin
    state_nxt = state;
    pick0     = 1'b0;
    pick1     = 1'b0;
    c_we      = 1'b0;
    c_re      = 1'b0;
    c_addr    = addr0;
    c_wdata   = wdata0;
    unique case (state)
      CLEAR: begin
        c_we    = 1'b1;
        c_addr  = sweep_idx;
        c_wdata = '0;
        if (&sweep_idx) state_nxt = IDLE;
      end
      IDLE: begin
        pick0 = req0 & (~req1 | (rr == REQ_P0));
        pick1 = req1 & ~pick0;
        unique case (1'b1)
          pick1: begin
            c_addr  = addr1;
            c_wdata = wdata1;
            c_we    = we1;
            c_re    = ~we1;
          end
          pick0: begin
            c_we = we0;
            c_re = ~we0;
          end
          default: ;
        endcase
      end
    endcase
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      state     <= RST_STATE;
      rr        <= REQ_P0;
      sweep_idx <= '0;
      gnt0      <= 1'b0;
      gnt1      <= 1'b0;
      rvalid    <= 1'b0;
      rid       <= REQ_P0;
    end else begin
      state  <= state_nxt;
      gnt0   <= pick0;
      gnt1   <= pick1;
      rvalid <= c_re;
      if (state == CLEAR) sweep_idx <= sweep_idx + 1'b1;
      if (c_re) rid <= pick1 ? REQ_P1 : REQ_P0;
      // the port just served drops to lowest priority
      if (pick0 | pick1) rr <= pick0 ? REQ_P1 : REQ_P0;
    end
  end

`ifdef REGFILE_CLEAR_SWEEP_EN
  assign busy = (state == CLEAR);
`else
  assign busy = 1'b0;
`endif

  regfile_core #(
    .DATA_W(DATA_W),
    .ADDR_W(ADDR_W)
  ) u_core (
    .clock(clock),
    .rst_n(rst_n),
    .we   (c_we),
    .re   (c_re),
    .addr (c_addr),
    .wdata(c_wdata),
    .rdata(rdata)
  );
endmodule

// File: tb/tb_regfile_arbiter.sv
// Directed self-checking bench for regfile_arbiter.
// Covers both REGFILE_CLEAR_SWEEP_EN builds.
module tb_regfile_arbiter;
  logic       clock = 1'b0;
  logic       rst_n = 1'b0;
  logic       req0 = 1'b0;
  logic       we0 = 1'b0;
  logic [3:0] addr0 = '0;
  logic [7:0] wdata0 = '0;
  logic       req1 = 1'b0;
  logic       we1 = 1'b0;
  logic [3:0] addr1 = '0;
  logic [7:0] wdata1 = '0;
  logic       gnt0;
  logic       gnt1;
  logic [7:0] rdata;
  logic       rvalid;
  logic       rid;
  logic       busy;

  int checks = 0;
  int errors = 0;

  regfile_arbiter dut (
    .clock (clock),
    .rst_n (rst_n),
    .req0  (req0),
    .we0   (we0),
    .addr0 (addr0),
    .wdata0(wdata0),
    .req1  (req1),
    .we1   (we1),
    .addr1 (addr1),
    .wdata1(wdata1),
    .gnt0  (gnt0),
    .gnt1  (gnt1),
    .rdata (rdata),
    .rvalid(rvalid),
    .rid   (rid),
    .busy  (busy)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic quiet();
    req0 = 1'b0;
    req1 = 1'b0;
    we0  = 1'b0;
    we1  = 1'b0;
  endtask

  task automatic p0(input logic w, input logic [3:0] a,
                    input logic [7:0] d);
    req0 = 1'b1; we0 = w; addr0 = a; wdata0 = d;
  endtask

  task automatic p1(input logic w, input logic [3:0] a,
                    input logic [7:0] d);
    req1 = 1'b1; we1 = w; addr1 = a; wdata1 = d;
  endtask

  task automatic wait_sweep(input int exp_n);
    int n;
    n = 0;
    while (busy === 1'b1 && n < 40) begin
      @(negedge clock);
      chk("no_gnt_in_clear", {30'd0, gnt1, gnt0}, 0);
      n++;
    end
    chk("sweep_len", n, exp_n);
  endtask

  task automatic do_reset();
    quiet();
    rst_n = 1'b0;
    repeat (2) @(negedge clock);
    chk("rst_gnt", {30'd0, gnt1, gnt0}, 0);
    chk("rst_rvalid", rvalid, 0);
    chk("rst_rdata", rdata, 0);
    chk("rst_rid", rid, 0);
`ifdef REGFILE_CLEAR_SWEEP_EN
    chk("rst_busy", busy, 1);
    rst_n = 1'b1;
    p0(1'b0, 4'd0, 8'd0);
    wait_sweep(16);
    quiet();
`else
    chk("rst_busy", busy, 0);
    rst_n = 1'b1;
`endif
  endtask

  initial begin
    logic [7:0] exp1;
    logic [7:0] exp2;

    // 1 / 6: reset behaviour
    @(negedge clock);
    do_reset();
`ifdef REGFILE_CLEAR_SWEEP_EN
    for (int a = 0; a < 16; a++) begin
      p0(1'b0, 4'(a), 8'd0);
      @(negedge clock);
      chk("sweep_gnt0", gnt0, 1);
      chk("sweep_rvalid", rvalid, 1);
      chk("sweep_zero", rdata, 0);
    end
    quiet();
    @(negedge clock);
`else
    p0(1'b0, 4'd0, 8'd0);
    @(negedge clock);
    chk("t6_busy", busy, 0);
    chk("t6_gnt0", gnt0, 1);
    chk("t6_rvalid", rvalid, 1);
    chk("t6_rid", rid, 0);
    quiet();
    @(negedge clock);
`endif

    // 2: port0 write then port1 read
    p0(1'b1, 4'd3, 8'hA5);
    @(negedge clock);
    chk("t2_gnt0", gnt0, 1);
    chk("t2_gnt1", gnt1, 0);
    chk("t2_wr_rvalid", rvalid, 0);
    quiet();
    p1(1'b0, 4'd3, 8'd0);
    @(negedge clock);
    chk("t2_rd_gnt1", gnt1, 1);
    chk("t2_rd_gnt0", gnt0, 0);
    chk("t2_rvalid", rvalid, 1);
    chk("t2_rid", rid, 1);
    chk("t2_rdata", rdata, 8'hA5);
    quiet();
    @(negedge clock);
    chk("idle_gnt", {30'd0, gnt1, gnt0}, 0);
    chk("idle_rvalid", rvalid, 0);
    chk("idle_hold", rdata, 8'hA5);

    // 5: reset while rvalid is pending
    p0(1'b0, 4'd3, 8'd0);
    @(posedge clock);
    #1;
    chk("t5_pre_rvalid", rvalid, 1);
    rst_n = 1'b0;
    #1;
    chk("t5_async_rvalid", rvalid, 0);
    chk("t5_async_gnt0", gnt0, 0);
    chk("t5_async_rdata", rdata, 0);
    @(negedge clock);
    rst_n = 1'b1;
    quiet();

    // preload addr 1/2, then reset so rr restarts at port 0
`ifdef REGFILE_CLEAR_SWEEP_EN
    wait_sweep(16);
    exp1 = 8'h00;
    exp2 = 8'h00;
`else
    exp1 = 8'h11;
    exp2 = 8'h22;
`endif
    p0(1'b1, 4'd1, 8'h11);
    @(negedge clock);
    p0(1'b1, 4'd2, 8'h22);
    @(negedge clock);
    do_reset();

    // 3: both requesting continuously alternate 0,1,0,1,0,1
    p0(1'b0, 4'd1, 8'd0);
    p1(1'b0, 4'd2, 8'd0);
    for (int i = 0; i < 6; i++) begin
      @(negedge clock);
      chk("t3_gnt0", gnt0, (i % 2 == 0) ? 1 : 0);
      chk("t3_gnt1", gnt1, (i % 2 == 1) ? 1 : 0);
      chk("t3_rvalid", rvalid, 1);
      chk("t3_rid", rid, i % 2);
      chk("t3_rdata", rdata, (i % 2 == 0) ? exp1 : exp2);
    end
    quiet();
    @(negedge clock);
    chk("t3_done", {30'd0, gnt1, gnt0}, 0);

    // 4: same-address read/write collision with rr at port 1
    p0(1'b1, 4'd5, 8'h11);
    @(negedge clock);
    chk("t4_pre_gnt0", gnt0, 1);
    p0(1'b1, 4'd5, 8'h3C);
    p1(1'b0, 4'd5, 8'd0);
    @(negedge clock);
    chk("t4_gnt1_first", gnt1, 1);
    chk("t4_gnt0_wait", gnt0, 0);
    chk("t4_old_data", rdata, 8'h11);
    chk("t4_rid", rid, 1);
    req1 = 1'b0;
    @(negedge clock);
    chk("t4_gnt0_next", gnt0, 1);
    chk("t4_wr_rvalid", rvalid, 0);
    quiet();
    p1(1'b0, 4'd5, 8'd0);
    @(negedge clock);
    chk("t4_new_data", rdata, 8'h3C);

    // both write same address: port0 first, port1 later wins
    quiet();
    p0(1'b1, 4'd6, 8'h88);
    p1(1'b1, 4'd6, 8'h77);
    @(negedge clock);
    chk("ww_gnt0", gnt0, 1);
    req0 = 1'b0;
    @(negedge clock);
    chk("ww_gnt1", gnt1, 1);
    quiet();
    p0(1'b0, 4'd6, 8'd0);
    @(negedge clock);
    chk("ww_last_wins", rdata, 8'h77);
    chk("ww_rid", rid, 0);
    quiet();

`ifdef REGFILE_CLEAR_SWEEP_EN
    // 5: reset mid-sweep restarts at entry 0
    rst_n = 1'b0;
    @(negedge clock);
    rst_n = 1'b1;
    repeat (7) @(posedge clock);
    #1;
    rst_n = 1'b0;
    #1;
    chk("t5_mid_busy", busy, 1);
    chk("t5_mid_gnt", {30'd0, gnt1, gnt0}, 0);
    @(negedge clock);
    rst_n = 1'b1;
    wait_sweep(16);
    p0(1'b0, 4'd5, 8'd0);
    @(negedge clock);
    chk("t5_cleared", rdata, 0);
    quiet();
`endif

    @(negedge clock);
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end
endmodule
